// File: rtl/weight_loader.sv
`default_nettype none
// ============================================================================
//  weight_loader : weight-tile preload controller driving the top row of the
//                  systolic array (w_col/load_en) and the swap pulse shift_en.
//  Optional feature: WEIGHT_LOADER_REORDER_EN (tile buffer, natural row order)
//  Revision      : 1.0
// ============================================================================
module weight_loader #(
   parameter int ROWS   = 4,
   parameter int COLS   = 4,
   parameter int DATA_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [COLS*DATA_W-1:0] s_data,
   input  logic                   swap_go,
   output logic [COLS*DATA_W-1:0] w_col,
   output logic                   load_en,
   output logic                   shift_en,
   output logic                   loaded,
   output logic                   tile_done
);

   localparam int                 c_ROW_W    = COLS * DATA_W;
   localparam int                 c_CNT_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [c_CNT_W-1:0] c_LAST_ROW = c_CNT_W'(ROWS - 1);

   localparam logic [2:0] c_S_IDLE   = 3'd0;
`ifdef WEIGHT_LOADER_REORDER_EN
   localparam logic [2:0] c_S_FILL   = 3'd1;
   localparam logic [2:0] c_S_LOAD   = 3'd2;
`else
   localparam logic [2:0] c_S_STREAM = 3'd1;
   localparam logic [2:0] c_S_LAST   = 3'd2;
`endif
   localparam logic [2:0] c_S_WAIT   = 3'd3;
   localparam logic [2:0] c_S_PULSE  = 3'd4;

   logic [2:0]         r_state;
   logic [2:0]         w_state_nxt;
   logic [c_CNT_W-1:0] r_cnt;
   logic [c_CNT_W-1:0] w_cnt_nxt;
   logic               w_accept;

   logic [c_ROW_W-1:0] r_w_col;
   logic               r_load_en;
   logic               r_shift_en;
   logic               r_loaded;
   logic               r_tile_done;
   logic [c_ROW_W-1:0] w_w_col_nxt;
   logic               w_load_en_nxt;
   logic               w_shift_en_nxt;
   logic               w_loaded_nxt;
   logic               w_tile_done_nxt;

`ifdef WEIGHT_LOADER_REORDER_EN
   assign s_ready = (r_state == c_S_IDLE) || (r_state == c_S_FILL);
`else
   assign s_ready = (r_state == c_S_IDLE) || (r_state == c_S_STREAM);
`endif
   assign w_accept = s_valid && s_ready;

`ifdef WEIGHT_LOADER_REORDER_EN
   logic [c_ROW_W-1:0] r_buf [ROWS];
   logic [c_CNT_W-1:0] w_cnt_dec;

   assign w_cnt_dec = r_cnt - 1'b1;

   // Tile buffer is deliberately left out of reset; slots are written before use.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_buf[r_cnt] <= s_data;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= c_S_IDLE;
         r_cnt       <= '0;
         r_w_col     <= '0;
         r_load_en   <= 1'b0;
         r_shift_en  <= 1'b0;
         r_loaded    <= 1'b0;
         r_tile_done <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_w_col     <= w_w_col_nxt;
         r_load_en   <= w_load_en_nxt;
         r_shift_en  <= w_shift_en_nxt;
         r_loaded    <= w_loaded_nxt;
         r_tile_done <= w_tile_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
`ifdef WEIGHT_LOADER_REORDER_EN
         c_S_IDLE, c_S_FILL: begin
            if (w_accept) begin
               w_state_nxt = (r_cnt == c_LAST_ROW) ? c_S_LOAD : c_S_FILL;
            end
         end
         c_S_LOAD: begin
            if (r_cnt == '0) begin
               w_state_nxt = c_S_WAIT;
            end
         end
`else
         c_S_IDLE, c_S_STREAM: begin
            if (w_accept) begin
               w_state_nxt = (r_cnt == c_LAST_ROW) ? c_S_LAST : c_S_STREAM;
            end
         end
         c_S_LAST:  w_state_nxt = c_S_WAIT;
`endif
         c_S_WAIT: begin
            if (swap_go) begin
               w_state_nxt = c_S_PULSE;
            end
         end
         c_S_PULSE: w_state_nxt = c_S_IDLE;
         default:   w_state_nxt = c_S_IDLE;
      endcase
   end

   // Output registers are loaded from the upcoming state, so load_en rises
   // in the cycle right after the accepting edge.
   always_comb begin
      w_cnt_nxt       = r_cnt;
      w_w_col_nxt     = '0;
      w_load_en_nxt   = 1'b0;
      w_shift_en_nxt  = 1'b0;
      w_loaded_nxt    = 1'b0;
      w_tile_done_nxt = 1'b0;
      case (r_state)
`ifdef WEIGHT_LOADER_REORDER_EN
         c_S_IDLE, c_S_FILL: begin
            if (w_accept) begin
               if (r_cnt == c_LAST_ROW) begin
                  // Bottom row goes out first, straight from the incoming beat.
                  w_cnt_nxt     = c_LAST_ROW;
                  w_w_col_nxt   = s_data;
                  w_load_en_nxt = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
         end
         c_S_LOAD: begin
            if (r_cnt != '0) begin
               w_cnt_nxt     = w_cnt_dec;
               w_w_col_nxt   = r_buf[w_cnt_dec];
               w_load_en_nxt = 1'b1;
            end else begin
               w_loaded_nxt = 1'b1;
            end
         end
`else
         c_S_IDLE, c_S_STREAM: begin
            if (w_accept) begin
               w_cnt_nxt     = (r_cnt == c_LAST_ROW) ? '0 : r_cnt + 1'b1;
               w_w_col_nxt   = s_data;
               w_load_en_nxt = 1'b1;
            end
         end
         c_S_LAST: w_loaded_nxt = 1'b1;
`endif
         c_S_WAIT: begin
            if (swap_go) begin
               w_shift_en_nxt  = 1'b1;
               w_tile_done_nxt = 1'b1;
            end else begin
               w_loaded_nxt = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign w_col     = r_w_col;
   assign load_en   = r_load_en;
   assign shift_en  = r_shift_en;
   assign loaded    = r_loaded;
   assign tile_done = r_tile_done;

endmodule
`default_nettype wire

// File: tb/tb_weight_loader.sv
`default_nettype none
// ============================================================================
//  tb_weight_loader : randomized self-checking bench for weight_loader with a
//                     transaction-level timing model (ROWS=4, COLS=2, DATA_W=8).
//  Revision         : 1.0
// ============================================================================
module tb_weight_loader;

   localparam int c_ROWS  = 4;
   localparam int c_COLS  = 2;
   localparam int c_DW    = 8;
   localparam int c_W     = c_COLS * c_DW;
   localparam int c_DEPTH = 4096;
   localparam int c_NEVER = 1 << 30;

   logic           clk;
   logic           rst;
   logic           s_valid;
   logic           s_ready;
   logic [c_W-1:0] s_data;
   logic           swap_go;
   logic [c_W-1:0] w_col;
   logic           load_en;
   logic           shift_en;
   logic           loaded;
   logic           tile_done;

   weight_loader #(.ROWS(c_ROWS), .COLS(c_COLS), .DATA_W(c_DW)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .swap_go   (swap_go),
      .w_col     (w_col),
      .load_en   (load_en),
      .shift_en  (shift_en),
      .loaded    (loaded),
      .tile_done (tile_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit armed    = 1'b0;

   // Expected per-cycle events, indexed by absolute cycle number.
   bit             e_load  [c_DEPTH];
   logic [c_W-1:0] e_wcol  [c_DEPTH];
   bit             e_pulse [c_DEPTH];
   logic [c_W-1:0] rows[$];
   bit             busy         = 1'b0;
   int             loaded_start = c_NEVER;
   int             release_c    = c_NEVER;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [c_W-1:0] row_word(input int i);
      logic [7:0] lo;
      logic [7:0] hi;
      lo = 8'(2 * i + 1);
      hi = 8'(2 * i + 2);
      return {hi, lo};
   endfunction

   task automatic step(input logic v, input logic [c_W-1:0] d, input logic sg, input logic r);
      bit exp_ready;
      bit exp_loaded;
      @(negedge clk);
      rst     = r;
      s_valid = v;
      s_data  = d;
      swap_go = sg;
      #1;
      if (busy && cyc >= release_c) begin
         busy         = 1'b0;
         release_c    = c_NEVER;
         loaded_start = c_NEVER;
      end
      exp_ready  = !busy;
      exp_loaded = busy && (cyc >= loaded_start) && (release_c == c_NEVER);
      if (armed) begin
         chk("s_ready", 32'(s_ready), 32'(exp_ready));
         chk("load_en", 32'(load_en), 32'(e_load[cyc]));
         if (e_load[cyc]) chk("w_col", 32'(w_col), 32'(e_wcol[cyc]));
         chk("loaded", 32'(loaded), 32'(exp_loaded));
         chk("shift_en", 32'(shift_en), 32'(e_pulse[cyc]));
         chk("tile_done", 32'(tile_done), 32'(e_pulse[cyc]));
      end
      if (r) begin
         rows.delete();
         busy         = 1'b0;
         loaded_start = c_NEVER;
         release_c    = c_NEVER;
         for (int i = cyc + 1; i < cyc + 12; i++) begin
            e_load[i]  = 1'b0;
            e_pulse[i] = 1'b0;
         end
         armed = 1'b1;
      end else begin
         if (sg && exp_loaded) begin
            e_pulse[cyc + 1] = 1'b1;
            release_c        = cyc + 2;
         end
         if (v && exp_ready) begin
            rows.push_back(d);
`ifndef WEIGHT_LOADER_REORDER_EN
            e_load[cyc + 1] = 1'b1;
            e_wcol[cyc + 1] = d;
`endif
            if (rows.size() == c_ROWS) begin
               busy = 1'b1;
`ifdef WEIGHT_LOADER_REORDER_EN
               for (int i = 0; i < c_ROWS; i++) begin
                  e_load[cyc + 1 + i] = 1'b1;
                  e_wcol[cyc + 1 + i] = rows[c_ROWS - 1 - i];
               end
               loaded_start = cyc + c_ROWS + 1;
`else
               loaded_start = cyc + 2;
`endif
               rows.delete();
            end
         end
      end
      cyc++;
   endtask

   task automatic send_tile();
      for (int i = 0; i < c_ROWS; i++) begin
`ifdef WEIGHT_LOADER_REORDER_EN
         step(1'b1, row_word(i), 1'b0, 1'b0);
`else
         step(1'b1, row_word(c_ROWS - 1 - i), 1'b0, 1'b0);
`endif
      end
   endtask

   task automatic idle(input int n, input logic sg);
      for (int i = 0; i < n; i++) step(1'b0, '0, sg, 1'b0);
   endtask

   initial begin
      logic [7:0] pat;
      rst     = 1'b1;
      s_valid = 1'b0;
      s_data  = '0;
      swap_go = 1'b0;

      // Reset held two cycles with a valid beat offered.
      step(1'b1, 16'h1111, 1'b0, 1'b1);
      step(1'b1, 16'h2222, 1'b0, 1'b1);
      idle(1, 1'b0);

      // Directed tile, swap held off then held high.
      send_tile();
      idle(4, 1'b0);
      idle(5, 1'b0);
      idle(4, 1'b1);
      idle(1, 1'b0);

      // Bubbles in the beat stream.
      pat = 8'b0100_1101;
      for (int i = 0; i < 7; i++) begin
         step(pat[6 - i], 16'($urandom), 1'b0, 1'b0);
      end
      idle(6, 1'b0);
      idle(3, 1'b1);
      idle(1, 1'b0);

      // Reset in the middle of the load phase, then a fresh tile.
      send_tile();
      idle(2, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1);
      idle(2, 1'b0);
      send_tile();
      idle(6, 1'b0);
      idle(2, 1'b1);
      idle(2, 1'b0);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 3) != 0), 16'($urandom),
              1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 63) == 0));
      end
      idle(c_ROWS + 2, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
